cond_exec_scheduler: RTL and testbench
======================================

// Module: cond_exec_scheduler
// PURPOSE
//  Issue-stage controller around the ConditionCheck evaluator. Owns the architectural NZCV status register.
//  Tracks in-flight flag-setting ops and stalls conditional instructions until their flags are final.
//  Emits a registered execute/kill decision per instruction, and a flush window for taken branches.
//  Sits between decode (ID) and execute (EX) of the 5-stage core.
// PARAMETERS
//  MAX_PENDING  4  max in-flight flag writers; a further S-bit op stalls at this count
//  FLUSH_CYC    2  cycles flush_req is held after a taken branch issues
// PORTS
//  clk           in   1  single clock, rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  id_valid      in   1  decode presents an instruction
//  id_ready      out  1  scheduler accepts; transfer occurs when id_valid & id_ready
//  id_cond       in   4  condition field (1110 = AL)
//  id_s_bit      in   1  instruction writes flags
//  id_is_branch  in   1  instruction is a branch
//  wb_flags_vld  in   1  a flag writer retires this cycle
//  wb_flags      in   4  retired flags {Z,C,V,N}
//  iss_valid     out  1  registered: instruction issued to EX
//  iss_exec      out  1  registered: condition passed; EX commits results
//  iss_s         out  1  registered: issued op is a live flag writer (iss_exec & id_s_bit)
//  flush_req     out  1  kill younger IF/ID contents
//  status_q      out  4  architectural {Z,C,V,N}
//  proto_err     out  1  sticky: wb_flags_vld seen with zero pending
// BEHAVIOUR
//  Reset: status_q=0, pending=0, state=RUN, and every output is 0 except id_ready=1.
//  Flag view (eff_flags): wb_flags when wb_flags_vld, else status_q. This is a same-cycle bypass into ConditionCheck.
//  status_q <= wb_flags on every wb_flags_vld.
//  Flags ready: pending==0, or (pending==1 & wb_flags_vld).
//  Condition "needs flags" unless id_cond is 1110 or 1111 (both always-true).
//  FSM states:
//   RUN   id_ready=1 only when neither of these holds:
//         - needs flags & flags not ready
//         - id_s_bit & pending==MAX_PENDING & ~wb_flags_vld
//         If id_valid and blocked, go to WAIT.
//   WAIT  id_ready=0. Return to RUN the cycle the blocking condition clears; accept in RUN on the next cycle.
//   FLUSH id_ready=0 and flush_req=1 for exactly FLUSH_CYC cycles (down-counter), then RUN.
//  Accept: next cycle, iss_valid=1 and iss_exec=ConditionCheck(id_cond, eff_flags). Latency is 1 cycle.
//  No accept: iss_valid=0, iss_exec=0, iss_s=0.
//  Taken branch (accept & exec & id_is_branch): enter FLUSH; flush_req rises with iss_valid.
//  Pending counter, width $clog2(MAX_PENDING+1):
//   +1 on accept & exec & id_s_bit
//   -1 on wb_flags_vld
//   both in the same cycle: unchanged
//   decrement at 0: hold 0 and set proto_err (status_q is still written)
//  A failed-condition S-bit op does not increment pending.
//  Async reset mid-flush or mid-wait returns to RUN immediately and drops all in-flight tracking.
// STRUCTURE
//  Shared package core_pkg:
//   COND_AL=4'b1110, COND_NV=4'b1111
//   flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_N=0
//   sched_state_t {RUN, WAIT, FLUSH}
//  Sub-module: instantiate existing ConditionCheck (condition=id_cond, status_flags=eff_flags).
//  Pending counter and FSM stay inline.
// TESTING
//  1 Reset held, then released.
//    -> status_q=0, id_ready=1, iss_valid=0, flush_req=0, proto_err=0.
//  2 SUBS (s=1, AL) accepted; next cycle EQ (0000) presented.
//    -> WAIT, id_ready=0 until wb_flags_vld with flags 4'b1000.
//    -> That cycle the state returns to RUN; the EQ op is accepted next cycle.
//    -> Then iss_valid=1, iss_exec=1, status_q=4'b1000.
//  3 pending=1; wb_flags_vld with flags 4'b0000 in the same cycle an NE (0001) is presented.
//    -> Bypass: accepted that cycle, iss_exec=1 next cycle, pending=0.
//  4 Four S-bit AL ops issued with no retire (MAX_PENDING=4); a fifth is presented.
//    -> id_ready=0.
//    -> A retire plus the fifth accept in the same cycle leaves pending=4.
//  5 Taken B with status_q Z=1, cond EQ.
//    -> iss_exec=1 and flush_req=1 for 2 cycles with id_ready=0, then RUN.
//    -> Repeat with Z=0: iss_exec=0 and no flush.
//  6 wb_flags_vld with pending=0.
//    -> proto_err=1 (sticky), pending stays 0, status_q updated.
//    -> rst_n low mid-FLUSH: flush_req=0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: condition encodings, NZCV bit positions and
// the issue-stage scheduler state type.
package core_pkg;

    // Both of these evaluate as always-true and never wait for flags.
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the packed {Z,C,V,N} status word.
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    // A condition depends on the flags unless it is one of the always-true codes.
    function automatic logic cond_needs_flags(input logic [3:0] cond);
        return !((cond == COND_AL) || (cond == COND_NV));
    endfunction

endpackage

// File: rtl/ConditionCheck.sv
// Purely combinational ARM-style condition evaluator over a {Z,C,V,N} word.
module ConditionCheck
    import core_pkg::*;
(
    input  logic [3:0] condition,
    input  logic [3:0] status_flags,
    output logic       cond_pass
);

    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic flag_n;

    assign flag_z = status_flags[FLAG_Z];
    assign flag_c = status_flags[FLAG_C];
    assign flag_v = status_flags[FLAG_V];
    assign flag_n = status_flags[FLAG_N];

    // Decode the condition field against the supplied flags.
    always_comb begin
        cond_pass = 1'b0;
        case (condition)
            4'b0000: cond_pass = flag_z;                             // EQ
            4'b0001: cond_pass = ~flag_z;                            // NE
            4'b0010: cond_pass = flag_c;                             // CS
            4'b0011: cond_pass = ~flag_c;                            // CC
            4'b0100: cond_pass = flag_n;                             // MI
            4'b0101: cond_pass = ~flag_n;                            // PL
            4'b0110: cond_pass = flag_v;                             // VS
            4'b0111: cond_pass = ~flag_v;                            // VC
            4'b1000: cond_pass = flag_c & ~flag_z;                   // HI
            4'b1001: cond_pass = ~flag_c | flag_z;                   // LS
            4'b1010: cond_pass = (flag_n == flag_v);                 // GE
            4'b1011: cond_pass = (flag_n != flag_v);                 // LT
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);       // GT
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);        // LE
            default: cond_pass = 1'b1;                               // AL / NV
        endcase
    end

endmodule

// File: rtl/cond_exec_scheduler.sv
// Issue-stage controller between ID and EX. Owns the architectural NZCV
// register, counts in-flight flag writers, holds back conditional ops until
// their flags are final and opens a flush window behind taken branches.
module cond_exec_scheduler
    import core_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int FLUSH_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [3:0] id_cond,
    input  logic       id_s_bit,
    input  logic       id_is_branch,
    input  logic       wb_flags_vld,
    input  logic [3:0] wb_flags,
    output logic       iss_valid,
    output logic       iss_exec,
    output logic       iss_s,
    output logic       flush_req,
    output logic [3:0] status_q,
    output logic       proto_err
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int FCNT_W = $clog2(FLUSH_CYC + 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYC);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

    sched_state_t      state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              iss_valid_q, iss_valid_d;
    logic              iss_exec_q, iss_exec_d;
    logic              iss_s_q, iss_s_d;
    logic              proto_err_q, proto_err_d;
    logic [3:0]        status_d;

    logic [3:0] eff_flags;
    logic       cond_ok;
    logic       needs_flags;
    logic       flags_ready;
    logic       pend_full;
    logic       blocked;
    logic       accept;
    logic       inc_pend;

    // Retiring flags are bypassed straight into this cycle's evaluation.
    assign eff_flags = wb_flags_vld ? wb_flags : status_q;

    ConditionCheck u_cond_check (
        .condition    (id_cond),
        .status_flags (eff_flags),
        .cond_pass    (cond_ok)
    );

    // Flags are final when nothing is in flight, or the last writer retires now.
    assign needs_flags = cond_needs_flags(id_cond);
    assign flags_ready = (pending_q == '0) || ((pending_q == PEND_ONE) && wb_flags_vld);
    assign pend_full   = id_s_bit && (pending_q == PEND_MAX) && !wb_flags_vld;
    assign blocked     = (needs_flags && !flags_ready) || pend_full;

    assign id_ready  = (state_q == RUN) && !blocked;
    assign accept    = id_valid && id_ready;
    assign inc_pend  = accept && cond_ok && id_s_bit;
    assign flush_req = (state_q == FLUSH);

    assign iss_valid = iss_valid_q;
    assign iss_exec  = iss_exec_q;
    assign iss_s     = iss_s_q;
    assign proto_err = proto_err_q;

    // Next state for the RUN/WAIT/FLUSH controller and the flush down-counter.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (id_valid && blocked) begin
                    state_d = WAIT;
                end else if (accept && cond_ok && id_is_branch) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_LOAD;
                end
            end
            WAIT: begin
                // Leave as soon as the stall reason is gone; acceptance happens in RUN.
                if (!(id_valid && blocked)) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (fcnt_q <= FCNT_ONE) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FCNT_ONE;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    // In-flight writer count, architectural flags and the sticky protocol error.
    always_comb begin
        pending_d   = pending_q;
        proto_err_d = proto_err_q;
        status_d    = status_q;
        if (wb_flags_vld) begin
            status_d = wb_flags;
            if (pending_q == '0) begin
                proto_err_d = 1'b1;
            end
        end
        if (inc_pend && !wb_flags_vld) begin
            pending_d = pending_q + PEND_ONE;
        end else if (!inc_pend && wb_flags_vld && (pending_q != '0)) begin
            pending_d = pending_q - PEND_ONE;
        end
    end

    // Issue decision presented to EX one cycle after acceptance.
    always_comb begin
        iss_valid_d = accept;
        iss_exec_d  = accept && cond_ok;
        iss_s_d     = accept && cond_ok && id_s_bit;
    end

    // State register; reset drops all in-flight tracking immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            pending_q   <= '0;
            proto_err_q <= 1'b0;
            status_q    <= 4'b0000;
            iss_valid_q <= 1'b0;
            iss_exec_q  <= 1'b0;
            iss_s_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pending_q   <= pending_d;
            proto_err_q <= proto_err_d;
            status_q    <= status_d;
            iss_valid_q <= iss_valid_d;
            iss_exec_q  <= iss_exec_d;
            iss_s_q     <= iss_s_d;
        end
    end

endmodule

// File: tb/tb_cond_exec_scheduler.sv
// Directed bench for cond_exec_scheduler with hand-computed expectations.
module tb_cond_exec_scheduler;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic       id_ready;
    logic [3:0] id_cond;
    logic       id_s_bit;
    logic       id_is_branch;
    logic       wb_flags_vld;
    logic [3:0] wb_flags;
    logic       iss_valid;
    logic       iss_exec;
    logic       iss_s;
    logic       flush_req;
    logic [3:0] status_q;
    logic       proto_err;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_NE = 4'b0001;
    localparam logic [3:0] C_AL = 4'b1110;

    cond_exec_scheduler #(.MAX_PENDING(4), .FLUSH_CYC(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_cond      (id_cond),
        .id_s_bit     (id_s_bit),
        .id_is_branch (id_is_branch),
        .wb_flags_vld (wb_flags_vld),
        .wb_flags     (wb_flags),
        .iss_valid    (iss_valid),
        .iss_exec     (iss_exec),
        .iss_s        (iss_s),
        .flush_req    (flush_req),
        .status_q     (status_q),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic s, input logic b);
        id_valid     = v;
        id_cond      = c;
        id_s_bit     = s;
        id_is_branch = b;
    endtask

    task automatic retire(input logic v, input logic [3:0] f);
        wb_flags_vld = v;
        wb_flags     = f;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, C_AL, 1'b0, 1'b0);
        retire(1'b0, 4'b0000);
        repeat (3) step();

        // 1: reset state, then release.
        chk("rst_status", 32'(status_q), 32'h0);
        chk("rst_id_ready", 32'(id_ready), 32'h1);
        rst_n = 1'b1;
        step();
        chk("rel_iss_valid", 32'(iss_valid), 32'h0);
        chk("rel_flush", 32'(flush_req), 32'h0);
        chk("rel_proto_err", 32'(proto_err), 32'h0);
        chk("rel_id_ready", 32'(id_ready), 32'h1);

        // 2: SUBS then EQ stalls until the writer retires.
        drive(1'b1, C_AL, 1'b1, 1'b0);
        #1 chk("subs_ready", 32'(id_ready), 32'h1);
        step();
        chk("subs_iss_valid", 32'(iss_valid), 32'h1);
        chk("subs_iss_s", 32'(iss_s), 32'h1);
        chk("subs_pending", 32'(dut.pending_q), 32'h1);
        drive(1'b1, C_EQ, 1'b0, 1'b0);
        #1 chk("eq_blocked", 32'(id_ready), 32'h0);
        step();
        chk("eq_wait_ready", 32'(id_ready), 32'h0);
        chk("eq_wait_iss_valid", 32'(iss_valid), 32'h0);
        retire(1'b1, 4'b1000);
        #1 chk("eq_wait_retire_ready", 32'(id_ready), 32'h0);
        step();
        retire(1'b0, 4'b0000);
        #1 chk("eq_run_ready", 32'(id_ready), 32'h1);
        chk("eq_status", 32'(status_q), 32'h8);
        chk("eq_no_issue_yet", 32'(iss_valid), 32'h0);
        step();
        drive(1'b0, C_AL, 1'b0, 1'b0);
        chk("eq_iss_valid", 32'(iss_valid), 32'h1);
        chk("eq_iss_exec", 32'(iss_exec), 32'h1);
        chk("eq_iss_s", 32'(iss_s), 32'h0);

        // 3: same-cycle retire bypass for NE.
        drive(1'b1, C_AL, 1'b1, 1'b0);
        step();
        chk("byp_pending1", 32'(dut.pending_q), 32'h1);
        drive(1'b1, C_NE, 1'b0, 1'b0);
        retire(1'b1, 4'b0000);
        #1 chk("byp_ready", 32'(id_ready), 32'h1);
        step();
        drive(1'b0, C_AL, 1'b0, 1'b0);
        retire(1'b0, 4'b0000);
        chk("byp_iss_valid", 32'(iss_valid), 32'h1);
        chk("byp_iss_exec", 32'(iss_exec), 32'h1);
        chk("byp_pending0", 32'(dut.pending_q), 32'h0);
        chk("byp_status", 32'(status_q), 32'h0);

        // 4: fill to MAX_PENDING, fifth stalls, retire+accept keeps 4.
        drive(1'b1, C_AL, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("fill_ready_%0d", i), 32'(id_ready), 32'h1);
            step();
        end
        chk("fill_pending4", 32'(dut.pending_q), 32'h4);
        #1 chk("full_blocked", 32'(id_ready), 32'h0);
        retire(1'b1, 4'b0000);
        #1 chk("full_retire_ready", 32'(id_ready), 32'h1);
        step();
        drive(1'b0, C_AL, 1'b0, 1'b0);
        chk("full_iss_s", 32'(iss_s), 32'h1);
        chk("full_pending_hold", 32'(dut.pending_q), 32'h4);
        retire(1'b1, 4'b1000);
        repeat (4) step();
        retire(1'b0, 4'b0000);
        chk("drain_pending0", 32'(dut.pending_q), 32'h0);
        chk("drain_status", 32'(status_q), 32'h8);
        chk("drain_proto_err", 32'(proto_err), 32'h0);

        // 5a: taken BEQ with Z=1 opens a two-cycle flush window.
        drive(1'b1, C_EQ, 1'b0, 1'b1);
        #1 chk("beq_ready", 32'(id_ready), 32'h1);
        step();
        drive(1'b0, C_AL, 1'b0, 1'b0);
        chk("beq_iss_exec", 32'(iss_exec), 32'h1);
        chk("beq_flush1", 32'(flush_req), 32'h1);
        chk("beq_ready_f1", 32'(id_ready), 32'h0);
        step();
        chk("beq_iss_valid_f2", 32'(iss_valid), 32'h0);
        chk("beq_flush2", 32'(flush_req), 32'h1);
        chk("beq_ready_f2", 32'(id_ready), 32'h0);
        step();
        chk("beq_flush_end", 32'(flush_req), 32'h0);
        chk("beq_ready_run", 32'(id_ready), 32'h1);

        // 5b: clear Z through a legitimate writer, then BEQ is not taken.
        drive(1'b1, C_AL, 1'b1, 1'b0);
        step();
        drive(1'b0, C_AL, 1'b0, 1'b0);
        retire(1'b1, 4'b0000);
        step();
        retire(1'b0, 4'b0000);
        chk("bnt_status", 32'(status_q), 32'h0);
        drive(1'b1, C_EQ, 1'b0, 1'b1);
        step();
        drive(1'b0, C_AL, 1'b0, 1'b0);
        chk("bnt_iss_valid", 32'(iss_valid), 32'h1);
        chk("bnt_iss_exec", 32'(iss_exec), 32'h0);
        chk("bnt_flush", 32'(flush_req), 32'h0);
        step();
        chk("bnt_ready", 32'(id_ready), 32'h1);
        chk("bnt_flush_after", 32'(flush_req), 32'h0);

        // 6: spurious retire sets the sticky error and still writes flags.
        retire(1'b1, 4'b0110);
        step();
        retire(1'b0, 4'b0000);
        chk("perr_set", 32'(proto_err), 32'h1);
        chk("perr_pending", 32'(dut.pending_q), 32'h0);
        chk("perr_status", 32'(status_q), 32'h6);
        step();
        chk("perr_sticky", 32'(proto_err), 32'h1);

        // 6b: asynchronous reset in the middle of a flush.
        drive(1'b1, C_AL, 1'b0, 1'b1);
        step();
        drive(1'b0, C_AL, 1'b0, 1'b0);
        chk("rflush_active", 32'(flush_req), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("rflush_drop", 32'(flush_req), 32'h0);
        chk("rflush_proto_err", 32'(proto_err), 32'h0);
        chk("rflush_status", 32'(status_q), 32'h0);
        chk("rflush_ready", 32'(id_ready), 32'h1);
        step();
        rst_n = 1'b1;
        step();
        chk("rflush_run", 32'(flush_req), 32'h0);
        chk("rflush_iss_valid", 32'(iss_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
